// File: rtl/dir_input.sv
// dir_input: debounces four active-low keys into press events and queues legal turns, releasing one per tick.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   key_n[3:0] raw active-low keys, asynchronous (0 up, 1 down, 2 right, 3 left)
//   tick       one-cycle pulse when the snake advances one block
//   cobra_dir  current heading (00 up, 01 down, 10 right, 11 left)
//   pending    number of queued turns, 0..QUEUE_DEPTH
//   dropped    one-cycle pulse when a legal press is lost to a full queue
module dir_input #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int QUEUE_DEPTH     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_n,
   input  logic       tick,
   output logic [1:0] cobra_dir,
   output logic [2:0] pending,
   output logic       dropped
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PTR_MAX = PW'(QUEUE_DEPTH - 1);
   localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

   logic [3:0] sync1_q, sync2_q, stable_q, stable_d, stable_prev_q, ev;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [1:0] fifo_q [QUEUE_DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, tail;
   logic [1:0] cand, last, cobra_dir_q, cobra_dir_d;
   logic [2:0] pending_q, pending_d;
   logic dropped_q, dropped_d, legal, push, pop;

   // The counter only runs while the synchronised level disagrees with the accepted one;
   // any agreeing sample restarts the count, so short glitches never flip stable.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Press is a debounced 1->0 edge; the key index is also the direction code.
   assign ev = stable_prev_q & ~stable_q;
   assign cand = ev[0] ? 2'd0 : ev[1] ? 2'd1 : ev[2] ? 2'd2 : 2'd3;

   // Legality is judged against the newest queued turn, not the current heading.
   assign tail = (wr_q == '0) ? PTR_MAX : wr_q - 1'b1;
   assign last = (pending_q != 3'd0) ? fifo_q[tail] : cobra_dir_q;
   assign legal = (|ev) && cand != last && cand != (last ^ 2'b01);

   // A full queue still accepts a push when a tick frees the head in the same cycle.
   assign push = legal && (pending_q != DEPTH || tick);
   assign pop = tick && pending_q != 3'd0;

   always_comb begin
      rd_d = pop ? ((rd_q == PTR_MAX) ? '0 : rd_q + 1'b1) : rd_q;
      wr_d = push ? ((wr_q == PTR_MAX) ? '0 : wr_q + 1'b1) : wr_q;
      cobra_dir_d = pop ? fifo_q[rd_q] : cobra_dir_q;
      pending_d = pending_q + {2'b00, push} - {2'b00, pop};
      dropped_d = legal && !push;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         stable_q <= 4'hF;
         stable_prev_q <= 4'hF;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         rd_q <= '0;
         wr_q <= '0;
         cobra_dir_q <= 2'b10;
         pending_q <= 3'd0;
         dropped_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         stable_q <= stable_d;
         stable_prev_q <= stable_q;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         rd_q <= rd_d;
         wr_q <= wr_d;
         cobra_dir_q <= cobra_dir_d;
         pending_q <= pending_d;
         dropped_q <= dropped_d;
      end
   end

   // Storage needs no reset: entries are only read while pending counts them as valid.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_q] <= cand;
   end

   assign cobra_dir = cobra_dir_q;
   assign pending = pending_q;
   assign dropped = dropped_q;
endmodule

// File: tb/tb_dir_input.sv
// tb_dir_input: directed table, corner sequences and random stimulus checked against a queue-based model.
module tb_dir_input;
   localparam int DC = 4;
   localparam int QD = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] key_n = 4'hF;
   logic tick = 1'b0;
   logic [1:0] cobra_dir;
   logic [2:0] pending;
   logic dropped;

   int nvec = 0;
   int nerr = 0;

   dir_input #(.DEBOUNCE_CYCLES(DC), .QUEUE_DEPTH(QD)) dut (
      .clk(clk),
      .reset(reset),
      .key_n(key_n),
      .tick(tick),
      .cobra_dir(cobra_dir),
      .pending(pending),
      .dropped(dropped)
   );

   always #5 clk = ~clk;

   // Reference model: keys pass two sample delays, a level is accepted after DC consecutive
   // disagreeing samples, presses become queue pushes subject to the turn rules.
   logic [3:0] m_s1, m_s2, m_st, m_pst;
   int m_run [4];
   logic [1:0] m_q [$];
   logic [1:0] m_dir;
   logic m_drop;

   task automatic model_step();
      logic [3:0] ev;
      logic [1:0] last;
      int c;
      int pre;
      if (reset) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_st = 4'hF; m_pst = 4'hF;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_q.delete();
         m_dir = 2'b10;
         m_drop = 1'b0;
      end else begin
         ev = m_pst & ~m_st;
         c = -1;
         for (int i = 3; i >= 0; i--) if (ev[i]) c = i;
         m_drop = 1'b0;
         pre = m_q.size();
         last = (pre > 0) ? m_q[$] : m_dir;
         if (tick && pre > 0) m_dir = m_q.pop_front();
         if (c >= 0 && 2'(c) != last && 2'(c) != (last ^ 2'b01)) begin
            if (pre < QD || tick) m_q.push_back(2'(c));
            else m_drop = 1'b1;
         end
         m_pst = m_st;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_st[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_st[i] = m_s2[i];
                  m_run[i] = 0;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = key_n;
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("model_dir", {6'd0, cobra_dir}, {6'd0, m_dir});
      chk("model_pending", {5'd0, pending}, 8'(m_q.size()));
      chk("model_dropped", {7'd0, dropped}, {7'd0, m_drop});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
   endtask

   typedef struct {
      logic [3:0] keys;
      int ticks;
      logic [1:0] dir;
      logic [2:0] pend;
   } vec_t;

   vec_t tbl [16];
   int nd;

   initial begin
      tbl[0]  = '{4'b0100, 1, 2'b10, 3'd0};
      tbl[1]  = '{4'b1000, 0, 2'b10, 3'd0};
      tbl[2]  = '{4'b0001, 0, 2'b10, 3'd1};
      tbl[3]  = '{4'b1000, 0, 2'b10, 3'd2};
      tbl[4]  = '{4'b0000, 1, 2'b00, 3'd1};
      tbl[5]  = '{4'b0000, 1, 2'b11, 3'd0};
      tbl[6]  = '{4'b0000, 1, 2'b11, 3'd0};
      tbl[7]  = '{4'b0001, 0, 2'b11, 3'd1};
      tbl[8]  = '{4'b0010, 0, 2'b11, 3'd1};
      tbl[9]  = '{4'b0100, 0, 2'b11, 3'd2};
      tbl[10] = '{4'b0000, 2, 2'b10, 3'd0};
      tbl[11] = '{4'b0001, 1, 2'b00, 3'd0};
      tbl[12] = '{4'b1000, 1, 2'b11, 3'd0};
      tbl[13] = '{4'b0101, 0, 2'b11, 3'd1};
      tbl[14] = '{4'b0000, 1, 2'b00, 3'd0};
      tbl[15] = '{4'b1001, 0, 2'b00, 3'd0};

      // Reset state, then idle ticks keep heading right
      idle(3);
      chk("reset_dir", {6'd0, cobra_dir}, 8'h2);
      chk("reset_pending", {5'd0, pending}, 8'h0);
      chk("reset_dropped", {7'd0, dropped}, 8'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) do_tick();
      chk("idle_ticks_dir", {6'd0, cobra_dir}, 8'h2);

      // Press latency: pending rises on the 7th edge after the first low sample
      key_n = 4'b1110;
      for (int c = 1; c <= 20; c++) begin
         cycle();
         chk("press_latency", {5'd0, pending}, (c >= 7) ? 8'h1 : 8'h0);
      end
      key_n = 4'hF;
      idle(8);
      do_tick();
      chk("first_turn_dir", {6'd0, cobra_dir}, 8'h0);
      chk("first_turn_pending", {5'd0, pending}, 8'h0);

      // Bounce on left key: 3 low / 1 high never settles
      for (int r = 0; r < 5; r++) begin
         key_n = 4'b0111;
         idle(3);
         key_n = 4'hF;
         idle(1);
      end
      idle(8);
      chk("bounce_pending", {5'd0, pending}, 8'h0);

      for (int v = 0; v < 16; v++) begin
         if (tbl[v].keys != 4'd0) begin
            key_n = ~tbl[v].keys;
            idle(10);
            key_n = 4'hF;
         end
         idle(8);
         for (int t = 0; t < tbl[v].ticks; t++) do_tick();
         chk($sformatf("tbl%0d_dir", v), {6'd0, cobra_dir}, {6'd0, tbl[v].dir});
         chk($sformatf("tbl%0d_pending", v), {5'd0, pending}, {5'd0, tbl[v].pend});
      end

      // Fill queue with right, up; third legal press (left) is dropped once
      key_n = 4'b1011; idle(10); key_n = 4'hF; idle(8);
      key_n = 4'b1110; idle(10); key_n = 4'hF; idle(8);
      chk("full_pending", {5'd0, pending}, 8'h2);
      nd = 0;
      key_n = 4'b0111;
      for (int c = 0; c < 10; c++) begin
         cycle();
         nd += int'(dropped);
      end
      key_n = 4'hF;
      idle(8);
      chk("drop_pulses", 8'(nd), 8'h1);
      chk("drop_pending", {5'd0, pending}, 8'h2);

      // Full queue, legal press lands on the same edge as a tick
      key_n = 4'b0111;
      for (int c = 1; c <= 10; c++) begin
         tick = (c == 7);
         cycle();
         if (c == 7) begin
            chk("push_pop_pending", {5'd0, pending}, 8'h2);
            chk("push_pop_dropped", {7'd0, dropped}, 8'h0);
            chk("push_pop_dir", {6'd0, cobra_dir}, 8'h2);
         end
      end
      tick = 1'b0;
      key_n = 4'hF;
      idle(8);
      do_tick();
      chk("drain1_dir", {6'd0, cobra_dir}, 8'h0);
      do_tick();
      chk("drain2_dir", {6'd0, cobra_dir}, 8'h3);
      chk("drain_pending", {5'd0, pending}, 8'h0);

      // Reset mid-debounce abandons the press
      key_n = 4'b1101;
      idle(3);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      key_n = 4'hF;
      idle(12);
      chk("mid_reset_pending", {5'd0, pending}, 8'h0);
      chk("mid_reset_dir", {6'd0, cobra_dir}, 8'h2);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(11) == 0) key_n = 4'($urandom);
         tick = ($urandom_range(5) == 0);
         reset = ($urandom_range(499) == 0);
         cycle();
      end
      reset = 1'b0;
      tick = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
